y86_execute_stage: RTL and testbench
====================================

// Module: y86_execute_stage
// PURPOSE
//  Execute stage of the Y86-64 pipeline; sits between decode and memory and wraps the 64-bit ALU.
//  Holds the E pipeline register and selects ALU operands and opcode.
//  Holds the condition-code register (ZF/SF/OF) and evaluates Cnd for jXX and cmovXX.
//  Produces e_* values for the M register and for forwarding.
//  The ALU is external; it is driven via alu_* ports and res = alu_a <op> alu_b.
// PARAMETERS
//  W       64     datapath width
//  RNONE   4'hF   "no register" ID
//  S_AOK   3'd1   status code for normal operation
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  e_bubble     in   1   load a bubble (NOP) into the E register at the next edge
//  mw_exc       in   1   M or W stage holds ADR/INS/HLT; blocks the CC update
//  d_stat       in   3   status from decode
//  d_icode      in   4   instruction code from decode
//  d_ifun       in   4   function code from decode
//  d_valC       in   W   constant word
//  d_valA       in   W   operand A
//  d_valB       in   W   operand B
//  d_dstE       in   4   destination register for valE
//  d_dstM       in   4   destination register for valM
//  alu_opcode   out  2   ALU op: 00 add, 01 sub, 10 and, 11 xor
//  alu_a        out  W   ALU left operand (aluB)
//  alu_b        out  W   ALU right operand (aluA)
//  alu_res      in   W   ALU result
//  alu_overflow in   1   ALU signed overflow
//  alu_zero     in   1   ALU result is zero
//  e_stat       out  3   E-register status
//  e_icode      out  4   E-register instruction code
//  e_cnd        out  1   condition outcome
//  e_valE       out  W   = alu_res
//  e_valA       out  W   E-register valA, passed through
//  e_dstE       out  4   destination for valE; RNONE when a cmov is not taken
//  e_dstM       out  4   E-register dstM
//  cc_out       out  3   {ZF,SF,OF}
// BEHAVIOUR
//  Reset / bubble state of the E register:
//   - stat=S_AOK, icode=1 (NOP), ifun=0, valC/valA/valB=0, dstE/dstM=RNONE.
//  Reset value of the CC register: 3'b100.
//  Reset values of outputs, given a conforming ALU:
//   - e_cnd=0, e_valE=0, alu_opcode=00, alu_a=alu_b=0, e_stat=S_AOK, e_icode=1, e_valA=0, e_dstE=e_dstM=RNONE.
//  rst_n assertion mid-operation clears the E register and CC immediately; the in-flight instruction is discarded.
//  E register edge behaviour:
//   - Loads the d_* inputs on each rising edge.
//   - e_bubble=1 loads the bubble state instead; bubble wins over the d_* inputs.
//   - The E register has no stall.
//  All e_* and alu_* outputs are combinational from the E register, CC, and alu_* inputs (0-cycle latency after the E edge).
//  aluA selection:
//   - icode 2 or 6: valA.
//   - icode 3, 4, 5: valC.
//   - icode 8 or A: -8.
//   - icode 9 or B: +8.
//   - otherwise: 0.
//  aluB selection:
//   - icode 4, 5, 6, 8, 9, A, B: valB.
//   - otherwise: 0.
//  alu_a=aluB and alu_b=aluA, so subq gives valB-valA.
//  alu_opcode = ifun[1:0] when icode==6, else 00.
//  OPq with ifun>3 is treated as undefined; decode is responsible for flagging it INS.
//  set_cc = (icode==6) & ~mw_exc & (e_stat==S_AOK).
//  When set_cc=1, the next edge loads CC <= {alu_zero, alu_res[W-1], alu_overflow}.
//  When set_cc=0, CC holds.
//  CC update and E-register load happen on the same edge.
//  A flag-consuming instruction behind an OPq sees the updated CC in the following cycle.
//  Cnd is evaluated from the current CC register, not from the ALU outputs, for icode 2 and 7:
//   - ifun 0: always true.
//   - ifun 1 (le): (SF^OF)|ZF.
//   - ifun 2 (l): SF^OF.
//   - ifun 3 (e): ZF.
//   - ifun 4 (ne): ~ZF.
//   - ifun 5 (ge): ~(SF^OF).
//   - ifun 6 (g): ~(SF^OF)&~ZF.
//   - ifun >6: 0.
//  e_cnd = 0 for all other icodes.
//  e_dstE = RNONE when icode==2 and e_cnd==0; otherwise the registered dstE.
//  Arithmetic wraps modulo 2^W; the ±8 constants are W-bit two's complement.
// TESTING
//  T1 reset: rst_n=0 mid-run -> immediately e_icode=1, e_dstE=F, cc_out=100, e_cnd=0, e_valE=0.
//  T2 subq: icode6 ifun1 valA=5 valB=5 -> alu_opcode=01, e_valE=0; after the edge cc_out=100.
//     Then valA=5 valB=3 -> e_valE=-2; after the edge cc_out=010.
//  T3 andq: ifun2 valA=0x0F valB=0xFF -> alu_opcode=10, e_valE=0x0F.
//     Same OPq with mw_exc=1 -> CC unchanged.
//  T4 cmovl: with CC=100, icode2 ifun2 dstE=3 -> e_cnd=0, e_dstE=F.
//     With CC=010 -> e_cnd=1, e_dstE=3, e_valE=valA.
//  T5 push/pop: icodeA valB=0x100 -> e_valE=0xF8, CC unchanged.
//     icodeB valB=0xF8 -> e_valE=0x100.
//  T6 bubble/jXX: e_bubble=1 with an OPq on d_* -> next cycle e_icode=1, CC unchanged.
//     jg (icode7 ifun6) with CC=000 -> e_cnd=1.

Source files
------------

// File: rtl/y86_execute_stage_if.sv
// Decode-side inputs, ALU handshake and E-stage outputs of the Y86-64 execute stage.
// The slave modport is the execute stage's view; master is the surrounding pipeline/ALU.
interface y86_execute_stage_if #(
   parameter int unsigned W = 64
);
   logic         e_bubble;
   logic         mw_exc;
   logic [2:0]   d_stat;
   logic [3:0]   d_icode;
   logic [3:0]   d_ifun;
   logic [W-1:0] d_valC;
   logic [W-1:0] d_valA;
   logic [W-1:0] d_valB;
   logic [3:0]   d_dstE;
   logic [3:0]   d_dstM;
   logic [1:0]   alu_opcode;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [W-1:0] alu_res;
   logic         alu_overflow;
   logic         alu_zero;
   logic [2:0]   e_stat;
   logic [3:0]   e_icode;
   logic         e_cnd;
   logic [W-1:0] e_valE;
   logic [W-1:0] e_valA;
   logic [3:0]   e_dstE;
   logic [3:0]   e_dstM;
   logic [2:0]   cc_out;

   modport master (
      output e_bubble, mw_exc, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB, d_dstE, d_dstM,
      output alu_res, alu_overflow, alu_zero,
      input  alu_opcode, alu_a, alu_b,
      input  e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM, cc_out
   );

   modport slave (
      input  e_bubble, mw_exc, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB, d_dstE, d_dstM,
      input  alu_res, alu_overflow, alu_zero,
      output alu_opcode, alu_a, alu_b,
      output e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM, cc_out
   );
endinterface

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU operand/opcode selection, condition codes
// and Cnd evaluation for jXX/cmovXX. The ALU itself sits outside and is reached through bus.
module y86_execute_stage #(
   parameter int unsigned W     = 64,
   parameter logic [3:0]  RNONE = 4'hF,
   parameter logic [2:0]  S_AOK = 3'd1
) (
   input logic                clk,
   input logic                rst_n,
   y86_execute_stage_if.slave bus
);
   localparam logic [3:0] IcHalt   = 4'h0;
   localparam logic [3:0] IcNop    = 4'h1;
   localparam logic [3:0] IcRrmovq = 4'h2;
   localparam logic [3:0] IcIrmovq = 4'h3;
   localparam logic [3:0] IcRmmovq = 4'h4;
   localparam logic [3:0] IcMrmovq = 4'h5;
   localparam logic [3:0] IcOpq    = 4'h6;
   localparam logic [3:0] IcJxx    = 4'h7;
   localparam logic [3:0] IcCall   = 4'h8;
   localparam logic [3:0] IcRet    = 4'h9;
   localparam logic [3:0] IcPushq  = 4'hA;
   localparam logic [3:0] IcPopq   = 4'hB;

   localparam logic [W-1:0] ConstPos8 = W'(8);
   localparam logic [W-1:0] ConstNeg8 = ~W'(7);
   localparam logic [2:0]   CcReset   = 3'b100;

   logic [2:0]   stat_q, stat_d;
   logic [3:0]   icode_q, icode_d;
   logic [3:0]   ifun_q, ifun_d;
   logic [W-1:0] valc_q, valc_d;
   logic [W-1:0] vala_q, vala_d;
   logic [W-1:0] valb_q, valb_d;
   logic [3:0]   dste_q, dste_d;
   logic [3:0]   dstm_q, dstm_d;
   logic [2:0]   cc_q, cc_d;

   logic [W-1:0] alu_a_sel;
   logic [W-1:0] alu_b_sel;
   logic         set_cc;
   logic         cnd;
   logic         zf, sf, of;

   // Bubble takes priority over whatever decode presents.
   always_comb begin
      stat_d  = bus.d_stat;
      icode_d = bus.d_icode;
      ifun_d  = bus.d_ifun;
      valc_d  = bus.d_valC;
      vala_d  = bus.d_valA;
      valb_d  = bus.d_valB;
      dste_d  = bus.d_dstE;
      dstm_d  = bus.d_dstM;
      if (bus.e_bubble) begin
         stat_d  = S_AOK;
         icode_d = IcNop;
         ifun_d  = 4'h0;
         valc_d  = '0;
         vala_d  = '0;
         valb_d  = '0;
         dste_d  = RNONE;
         dstm_d  = RNONE;
      end
   end

   assign set_cc = (icode_q == IcOpq) && !bus.mw_exc && (stat_q == S_AOK);

   always_comb begin
      cc_d = cc_q;
      if (set_cc) begin
         cc_d = {bus.alu_zero, bus.alu_res[W-1], bus.alu_overflow};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q  <= S_AOK;
         icode_q <= IcNop;
         ifun_q  <= 4'h0;
         valc_q  <= '0;
         vala_q  <= '0;
         valb_q  <= '0;
         dste_q  <= RNONE;
         dstm_q  <= RNONE;
         cc_q    <= CcReset;
      end else begin
         stat_q  <= stat_d;
         icode_q <= icode_d;
         ifun_q  <= ifun_d;
         valc_q  <= valc_d;
         vala_q  <= vala_d;
         valb_q  <= valb_d;
         dste_q  <= dste_d;
         dstm_q  <= dstm_d;
         cc_q    <= cc_d;
      end
   end

   // aluA feeds the right-hand ALU port so that subq computes valB - valA.
   always_comb begin
      alu_b_sel = '0;
      case (icode_q)
         IcRrmovq, IcOpq:           alu_b_sel = vala_q;
         IcIrmovq, IcRmmovq, IcMrmovq: alu_b_sel = valc_q;
         IcCall, IcPushq:           alu_b_sel = ConstNeg8;
         IcRet, IcPopq:             alu_b_sel = ConstPos8;
         default:                   alu_b_sel = '0;
      endcase
   end

   always_comb begin
      alu_a_sel = '0;
      case (icode_q)
         IcRmmovq, IcMrmovq, IcOpq, IcCall, IcRet, IcPushq, IcPopq: alu_a_sel = valb_q;
         default:                                                   alu_a_sel = '0;
      endcase
   end

   assign zf = cc_q[2];
   assign sf = cc_q[1];
   assign of = cc_q[0];

   always_comb begin
      cnd = 1'b0;
      if ((icode_q == IcRrmovq) || (icode_q == IcJxx)) begin
         case (ifun_q)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = (sf ^ of) | zf;
            4'h2:    cnd = sf ^ of;
            4'h3:    cnd = zf;
            4'h4:    cnd = ~zf;
            4'h5:    cnd = ~(sf ^ of);
            4'h6:    cnd = ~(sf ^ of) & ~zf;
            default: cnd = 1'b0;
         endcase
      end
   end

   assign bus.alu_opcode = (icode_q == IcOpq) ? ifun_q[1:0] : 2'b00;
   assign bus.alu_a      = alu_a_sel;
   assign bus.alu_b      = alu_b_sel;
   assign bus.e_stat     = stat_q;
   assign bus.e_icode    = icode_q;
   assign bus.e_cnd      = cnd;
   assign bus.e_valE     = bus.alu_res;
   assign bus.e_valA     = vala_q;
   assign bus.e_dstE     = ((icode_q == IcRrmovq) && !cnd) ? RNONE : dste_q;
   assign bus.e_dstM     = dstm_q;
   assign bus.cc_out     = cc_q;

   // IcHalt is named for completeness of the opcode map; it selects no operands.
   logic unused_halt;
   assign unused_halt = (icode_q == IcHalt);
endmodule

// File: tb/tb_y86_execute_stage.sv
// Randomized scoreboard bench for y86_execute_stage with a behavioural E-stage/ALU model.
module tb_y86_execute_stage;
   localparam int unsigned W = 64;

   typedef struct packed {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] valc;
      logic [63:0] vala;
      logic [63:0] valb;
      logic [3:0]  dste;
      logic [3:0]  dstm;
   } e_t;

   typedef struct packed {
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic        cnd;
      logic [63:0] vale;
      logic [63:0] vala;
      logic [3:0]  dste;
      logic [3:0]  dstm;
      logic [2:0]  cc;
      logic [1:0]  op;
      logic [63:0] lhs;
      logic [63:0] rhs;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   y86_execute_stage_if #(.W(W)) bus ();
   y86_execute_stage #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // External ALU: res = alu_a <op> alu_b.
   logic [63:0] alu_r;
   always_comb begin
      alu_r = 64'd0;
      bus.alu_overflow = 1'b0;
      case (bus.alu_opcode)
         2'b00: begin
            alu_r = bus.alu_a + bus.alu_b;
            bus.alu_overflow = (bus.alu_a[63] == bus.alu_b[63]) && (alu_r[63] != bus.alu_a[63]);
         end
         2'b01: begin
            alu_r = bus.alu_a - bus.alu_b;
            bus.alu_overflow = (bus.alu_a[63] != bus.alu_b[63]) && (alu_r[63] != bus.alu_a[63]);
         end
         2'b10:   alu_r = bus.alu_a & bus.alu_b;
         default: alu_r = bus.alu_a ^ bus.alu_b;
      endcase
      bus.alu_res  = alu_r;
      bus.alu_zero = (alu_r == 64'd0);
   end

   int checks = 0;
   int failures = 0;
   bit running = 1'b0;
   exp_t sb[$];
   e_t m_e;
   logic [2:0] m_cc;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic e_t bubble_e();
      e_t e;
      e = '{stat: 3'd1, icode: 4'h1, ifun: 4'h0, valc: 64'd0, vala: 64'd0, valb: 64'd0,
            dste: 4'hF, dstm: 4'hF};
      return e;
   endfunction

   function automatic e_t mk(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                             input logic [63:0] va, input logic [63:0] vb,
                             input logic [3:0] de, input logic [3:0] dm);
      e_t e;
      e = '{stat: 3'd1, icode: ic, ifun: fn, valc: vc, vala: va, valb: vb, dste: de, dstm: dm};
      return e;
   endfunction

   // Operands in ALU port order: lhs = aluB, rhs = aluA.
   function automatic void operands(input e_t e, output logic [63:0] lhs,
                                    output logic [63:0] rhs, output logic [1:0] op);
      case (e.icode)
         4'h2, 4'h6:       rhs = e.vala;
         4'h3, 4'h4, 4'h5: rhs = e.valc;
         4'h8, 4'hA:       rhs = 64'hFFFF_FFFF_FFFF_FFF8;
         4'h9, 4'hB:       rhs = 64'd8;
         default:          rhs = 64'd0;
      endcase
      lhs = (e.icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? e.valb : 64'd0;
      op  = (e.icode == 4'h6) ? e.ifun[1:0] : 2'b00;
   endfunction

   function automatic void alu_ref(input logic [63:0] l, input logic [63:0] r,
                                   input logic [1:0] op, output logic [63:0] res,
                                   output logic ovf);
      logic [64:0] wide;
      ovf = 1'b0;
      wide = 65'd0;
      case (op)
         2'b00: begin
            wide = {l[63], l} + {r[63], r};
            res = wide[63:0];
            ovf = wide[64] ^ wide[63];
         end
         2'b01: begin
            wide = {l[63], l} - {r[63], r};
            res = wide[63:0];
            ovf = wide[64] ^ wide[63];
         end
         2'b10:   res = l & r;
         default: res = l ^ r;
      endcase
   endfunction

   function automatic logic cond(input logic [3:0] fn, input logic [2:0] cc);
      bit zf, lt;
      zf = cc[2];
      lt = cc[1] ^ cc[0];
      case (fn)
         4'd0:    return 1'b1;
         4'd1:    return lt || zf;
         4'd2:    return lt;
         4'd3:    return zf;
         4'd4:    return !zf;
         4'd5:    return !lt;
         4'd6:    return !lt && !zf;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t predict(input e_t e, input logic [2:0] cc);
      exp_t x;
      logic [63:0] l, r, res;
      logic [1:0] op;
      logic ovf;
      operands(e, l, r, op);
      alu_ref(l, r, op, res, ovf);
      x.stat  = e.stat;
      x.icode = e.icode;
      x.cnd   = (e.icode == 4'h2 || e.icode == 4'h7) ? cond(e.ifun, cc) : 1'b0;
      x.vale  = res;
      x.vala  = e.vala;
      x.dste  = (e.icode == 4'h2 && !x.cnd) ? 4'hF : e.dste;
      x.dstm  = e.dstm;
      x.cc    = cc;
      x.op    = op;
      x.lhs   = l;
      x.rhs   = r;
      return x;
   endfunction

   function automatic logic [2:0] next_cc(input e_t e, input logic [2:0] cc, input logic mw);
      logic [63:0] l, r, res;
      logic [1:0] op;
      logic ovf;
      if (e.icode != 4'h6 || mw || e.stat != 3'd1) return cc;
      operands(e, l, r, op);
      alu_ref(l, r, op, res, ovf);
      return {res == 64'd0, res[63], ovf};
   endfunction

   task automatic drive(input e_t d, input logic bub, input logic mw);
      bus.d_stat   = d.stat;
      bus.d_icode  = d.icode;
      bus.d_ifun   = d.ifun;
      bus.d_valC   = d.valc;
      bus.d_valA   = d.vala;
      bus.d_valB   = d.valb;
      bus.d_dstE   = d.dste;
      bus.d_dstM   = d.dstm;
      bus.e_bubble = bub;
      bus.mw_exc   = mw;
   endtask

   // One cycle: present stimulus at the falling edge and queue the state expected after the rise.
   task automatic step(input e_t d, input logic bub, input logic mw);
      @(negedge clk);
      drive(d, bub, mw);
      m_cc = next_cc(m_e, m_cc, mw);
      m_e  = bub ? bubble_e() : d;
      sb.push_back(predict(m_e, m_cc));
   endtask

   task automatic mid_reset(input e_t garbage);
      @(negedge clk);
      drive(garbage, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_icode", {60'd0, bus.e_icode}, 64'd1);
      chk("rst_dstE", {60'd0, bus.e_dstE}, 64'hF);
      chk("rst_cc", {61'd0, bus.cc_out}, 64'h4);
      chk("rst_cnd", {63'd0, bus.e_cnd}, 64'd0);
      chk("rst_valE", bus.e_valE, 64'd0);
      m_e  = bubble_e();
      m_cc = 3'b100;
      sb.push_back(predict(m_e, m_cc));
      @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   function automatic logic [63:0] rand_val();
      int unsigned k;
      k = $urandom_range(0, 3);
      if (k == 0) return 64'($urandom_range(0, 15));
      if (k == 1) return {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))};
      return {$urandom, $urandom};
   endfunction

   function automatic e_t rand_instr();
      e_t e;
      int unsigned k;
      k = $urandom_range(0, 9);
      if (k <= 2) e.icode = 4'h6;
      else if (k <= 4) e.icode = 4'h2;
      else if (k == 5) e.icode = 4'h7;
      else e.icode = 4'($urandom_range(0, 15));
      if (e.icode == 4'h6) e.ifun = 4'($urandom_range(0, 3));
      else if (e.icode == 4'h2 || e.icode == 4'h7) e.ifun = 4'($urandom_range(0, 7));
      else e.ifun = 4'($urandom_range(0, 15));
      e.stat = ($urandom_range(0, 9) < 8) ? 3'd1 : 3'($urandom_range(0, 7));
      e.valc = rand_val();
      e.vala = rand_val();
      e.valb = ($urandom_range(0, 4) == 0) ? e.vala : rand_val();
      e.dste = 4'($urandom_range(0, 15));
      e.dstm = 4'($urandom_range(0, 15));
      return e;
   endfunction

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (running) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 64'd0, 64'd1);
            end else begin
               x = sb.pop_front();
               chk("e_stat", {61'd0, bus.e_stat}, {61'd0, x.stat});
               chk("e_icode", {60'd0, bus.e_icode}, {60'd0, x.icode});
               chk("e_cnd", {63'd0, bus.e_cnd}, {63'd0, x.cnd});
               chk("e_valE", bus.e_valE, x.vale);
               chk("e_valA", bus.e_valA, x.vala);
               chk("e_dstE", {60'd0, bus.e_dstE}, {60'd0, x.dste});
               chk("e_dstM", {60'd0, bus.e_dstM}, {60'd0, x.dstm});
               chk("cc_out", {61'd0, bus.cc_out}, {61'd0, x.cc});
               chk("alu_opcode", {62'd0, bus.alu_opcode}, {62'd0, x.op});
               chk("alu_a", bus.alu_a, x.lhs);
               chk("alu_b", bus.alu_b, x.rhs);
            end
         end
      end
   end

   initial begin : stimulus
      rst_n = 1'b0;
      drive(bubble_e(), 1'b0, 1'b0);
      m_e  = bubble_e();
      m_cc = 3'b100;
      sb.push_back(predict(m_e, m_cc));
      running = 1'b1;
      @(posedge clk);
      #3 rst_n = 1'b1;

      // subq equal, subq 3-5, andq, andq with downstream exception.
      step(mk(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h2, 4'hF), 1'b0, 1'b0);
      step(mk(4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 4'h2, 4'hF), 1'b0, 1'b0);
      step(mk(4'h6, 4'h2, 64'd0, 64'h0F, 64'hFF, 4'h2, 4'hF), 1'b0, 1'b0);
      step(mk(4'h6, 4'h2, 64'd0, 64'h0F, 64'hFF, 4'h2, 4'hF), 1'b0, 1'b1);
      // cmovl with CC 100 then with CC 010.
      step(mk(4'h6, 4'h1, 64'd0, 64'd7, 64'd7, 4'h2, 4'hF), 1'b0, 1'b1);
      step(mk(4'h2, 4'h2, 64'd0, 64'h77, 64'd0, 4'h3, 4'hF), 1'b0, 1'b0);
      step(mk(4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 4'h2, 4'hF), 1'b0, 1'b0);
      step(mk(4'h2, 4'h2, 64'd0, 64'h77, 64'd0, 4'h3, 4'hF), 1'b0, 1'b0);
      step(mk(4'h2, 4'h2, 64'd0, 64'h78, 64'd0, 4'h3, 4'hF), 1'b0, 1'b0);
      // pushq / popq stack pointer arithmetic.
      step(mk(4'hA, 4'h0, 64'd0, 64'h55, 64'h100, 4'h4, 4'hF), 1'b0, 1'b0);
      step(mk(4'hB, 4'h0, 64'd0, 64'h55, 64'hF8, 4'h4, 4'h5), 1'b0, 1'b0);
      // bubble over an OPq, then xorq to CC 000 and jg.
      step(mk(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h2, 4'hF), 1'b1, 1'b0);
      step(mk(4'h6, 4'h3, 64'd0, 64'd1, 64'd3, 4'h2, 4'hF), 1'b0, 1'b0);
      step(mk(4'h7, 4'h6, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF), 1'b0, 1'b0);
      step(mk(4'h7, 4'h6, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF), 1'b0, 1'b0);

      mid_reset(mk(4'h6, 4'h1, 64'd0, 64'd9, 64'd2, 4'h1, 4'h1));

      for (int i = 0; i < 400; i++) begin
         if (i == 200) mid_reset(rand_instr());
         step(rand_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      end

      @(posedge clk);
      #2;
      chk("sb_drain", 64'(sb.size()), 64'd0);
      running = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
